// File: rtl/sigma_tile_pkg.sv
// Shared sigma_tile definitions: tracer control bit positions, trace-controller
// CSR offsets and the trace-controller state type.
package sigma_tile_pkg;

  localparam int unsigned TRACE_EN_BIT    = 0;
  localparam int unsigned TRACE_FLUSH_BIT = 1;

  localparam logic [3:0] TRC_CSR_CTRL   = 4'h0;
  localparam logic [3:0] TRC_CSR_STATUS = 4'h4;
  localparam logic [3:0] TRC_CSR_CNT    = 4'h8;
  localparam logic [3:0] TRC_CSR_PTR    = 4'hC;

  typedef enum logic [2:0] {
    TRC_IDLE,
    TRC_FLUSH,
    TRC_D_REQ,
    TRC_D_WAIT,
    TRC_D_PUSH
  } trc_state_t;

endpackage

// File: rtl/mem_trace_csr.sv
// CSR register file for the trace controller: EN, drain count, sticky status
// flags and FLUSH/DRAIN command decode.
module mem_trace_csr
  import sigma_tile_pkg::*;
#(
  parameter int unsigned CAPACITY = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          csr_req,
  input  logic                          csr_we,
  input  logic [3:0]                    csr_addr,
  input  logic [31:0]                   csr_wdata,
  output logic                          csr_ack,
  output logic                          csr_resp,
  output logic [31:0]                   csr_rdata,
  input  logic                          busy_i,
  input  logic [$clog2(CAPACITY)-1:0]   drain_ptr_i,
  input  logic                          flush_done_set_i,
  input  logic                          drain_done_set_i,
  output logic                          en_o,
  output logic [$clog2(CAPACITY):0]     drain_cnt_o,
  output logic                          flush_cmd_o,
  output logic                          drain_cmd_o
);

  localparam int unsigned AW = $clog2(CAPACITY);
  localparam logic [AW:0] CNT_MAX = (AW+1)'(CAPACITY);

  logic          en_q, en_d;
  logic          flush_done_q, flush_done_d;
  logic          drain_done_q, drain_done_d;
  logic          cmd_err_q, cmd_err_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          resp_q, resp_d;
  logic [31:0]   rdata_q, rdata_d;

  logic wr, rd, wr_ctrl, wr_status, wr_cnt;
  logic cmd_flush, cmd_drain;

  assign csr_ack     = csr_req;
  assign csr_resp    = resp_q;
  assign csr_rdata   = rdata_q;
  assign en_o        = en_q;
  assign drain_cnt_o = cnt_q;

  always_comb begin
    wr        = csr_req & csr_we;
    rd        = csr_req & ~csr_we;
    wr_ctrl   = wr & (csr_addr == TRC_CSR_CTRL);
    wr_status = wr & (csr_addr == TRC_CSR_STATUS);
    wr_cnt    = wr & (csr_addr == TRC_CSR_CNT);
    cmd_flush = wr_ctrl & csr_wdata[1];
    cmd_drain = wr_ctrl & csr_wdata[2];

    // FLUSH takes priority over DRAIN; any command while busy, or both at once, is an error
    flush_cmd_o = cmd_flush & ~busy_i;
    drain_cmd_o = cmd_drain & ~cmd_flush & ~busy_i;

    en_d = en_q;
    if (wr_ctrl) en_d = csr_wdata[0];

    flush_done_d = flush_done_q;
    drain_done_d = drain_done_q;
    cmd_err_d    = cmd_err_q;
    if (wr_status) begin
      if (csr_wdata[1]) flush_done_d = 1'b0;
      if (csr_wdata[2]) drain_done_d = 1'b0;
      if (csr_wdata[3]) cmd_err_d    = 1'b0;
    end
    if (flush_done_set_i) flush_done_d = 1'b1;
    if (drain_done_set_i) drain_done_d = 1'b1;
    if (((cmd_flush | cmd_drain) & busy_i) | (cmd_flush & cmd_drain)) cmd_err_d = 1'b1;

    cnt_d = cnt_q;
    if (wr_cnt) begin
      if (csr_wdata == '0 || csr_wdata > 32'(CAPACITY)) cnt_d = CNT_MAX;
      else                                              cnt_d = csr_wdata[AW:0];
    end

    resp_d  = rd;
    rdata_d = '0;
    if (rd) begin
      case (csr_addr)
        TRC_CSR_CTRL:   rdata_d = {31'b0, en_q};
        TRC_CSR_STATUS: rdata_d = {28'b0, cmd_err_q, drain_done_q, flush_done_q, busy_i};
        TRC_CSR_CNT:    rdata_d = {{(31-AW){1'b0}}, cnt_q};
        TRC_CSR_PTR:    rdata_d = {{(32-AW){1'b0}}, drain_ptr_i};
        default:        rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q         <= 1'b0;
      flush_done_q <= 1'b0;
      drain_done_q <= 1'b0;
      cmd_err_q    <= 1'b0;
      cnt_q        <= CNT_MAX;
      resp_q       <= 1'b0;
      rdata_q      <= '0;
    end else begin
      en_q         <= en_d;
      flush_done_q <= flush_done_d;
      drain_done_q <= drain_done_d;
      cmd_err_q    <= cmd_err_d;
      cnt_q        <= cnt_d;
      resp_q       <= resp_d;
      rdata_q      <= rdata_d;
    end
  end

endmodule

// File: rtl/mem_trace_ctrl.sv
// Trace buffer sequencer: drives the tracer control word (enable/flush) and drains
// captured entries through the tracer read port as an address/data/we word stream.
module mem_trace_ctrl
  import sigma_tile_pkg::*;
#(
  parameter int unsigned CAPACITY = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_req,
  input  logic        csr_we,
  input  logic [3:0]  csr_addr,
  input  logic [31:0] csr_wdata,
  output logic        csr_ack,
  output logic        csr_resp,
  output logic [31:0] csr_rdata,
  output logic [3:0]  trace_ctrl_o,
  input  logic        trace_flush_end_i,
  output logic        trc_req,
  output logic [31:0] trc_addr,
  input  logic        trc_ack,
  input  logic        trc_resp,
  input  logic [31:0] trc_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_word,
  output logic        out_last
);

  localparam int unsigned AW = $clog2(CAPACITY);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  trc_state_t    state_q, state_d;
  logic [AW-1:0] i_q, i_d;
  logic [1:0]    w_q, w_d;
  logic [31:0]   data_q, data_d;
  logic [3:0]    trace_ctrl_q, trace_ctrl_d;

  logic          en, flush_cmd, drain_cmd, busy;
  logic          flush_done_set, drain_done_set;
  logic [AW:0]   drain_cnt;
  logic          is_last;

  mem_trace_csr #(
    .CAPACITY (CAPACITY)
  ) u_csr (
    .clk              (clk),
    .rst_n            (rst_n),
    .csr_req          (csr_req),
    .csr_we           (csr_we),
    .csr_addr         (csr_addr),
    .csr_wdata        (csr_wdata),
    .csr_ack          (csr_ack),
    .csr_resp         (csr_resp),
    .csr_rdata        (csr_rdata),
    .busy_i           (busy),
    .drain_ptr_i      (i_q),
    .flush_done_set_i (flush_done_set),
    .drain_done_set_i (drain_done_set),
    .en_o             (en),
    .drain_cnt_o      (drain_cnt),
    .flush_cmd_o      (flush_cmd),
    .drain_cmd_o      (drain_cmd)
  );

  assign busy      = (state_q != TRC_IDLE);
  assign is_last   = ({1'b0, i_q} == drain_cnt - CNT_ONE) && (w_q == 2'd2);
  assign trc_req   = (state_q == TRC_D_REQ);
  assign trc_addr  = trc_req ? {{(29-AW){1'b0}}, 1'b1, i_q, w_q} : '0;
  assign out_valid = (state_q == TRC_D_PUSH);
  assign out_data  = out_valid ? data_q : '0;
  assign out_word  = out_valid ? w_q : '0;
  assign out_last  = out_valid & is_last;
  assign trace_ctrl_o = trace_ctrl_q;

  always_comb begin
    state_d        = state_q;
    i_d            = i_q;
    w_d            = w_q;
    data_d         = data_q;
    flush_done_set = 1'b0;
    drain_done_set = 1'b0;

    case (state_q)
      TRC_IDLE: begin
        if (flush_cmd) begin
          state_d = TRC_FLUSH;
        end else if (drain_cmd) begin
          state_d = TRC_D_REQ;
          i_d     = '0;
          w_d     = '0;
        end
      end
      TRC_FLUSH: begin
        if (trace_flush_end_i) begin
          state_d        = TRC_IDLE;
          flush_done_set = 1'b1;
        end
      end
      TRC_D_REQ: begin
        if (trc_ack) state_d = TRC_D_WAIT;
      end
      TRC_D_WAIT: begin
        if (trc_resp) begin
          data_d  = trc_rdata;
          state_d = TRC_D_PUSH;
        end
      end
      TRC_D_PUSH: begin
        if (out_ready) begin
          if (w_q == 2'd2) begin
            w_d = '0;
            i_d = i_q + IDX_ONE;
          end else begin
            w_d = w_q + 2'd1;
          end
          if (is_last) begin
            state_d        = TRC_IDLE;
            drain_done_set = 1'b1;
          end else begin
            state_d = TRC_D_REQ;
          end
        end
      end
      default: state_d = TRC_IDLE;
    endcase

    trace_ctrl_d                  = '0;
    trace_ctrl_d[TRACE_EN_BIT]    = en & (state_q == TRC_IDLE);
    trace_ctrl_d[TRACE_FLUSH_BIT] = (state_q == TRC_FLUSH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= TRC_IDLE;
      i_q          <= '0;
      w_q          <= '0;
      data_q       <= '0;
      trace_ctrl_q <= '0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      w_q          <= w_d;
      data_q       <= data_d;
      trace_ctrl_q <= trace_ctrl_d;
    end
  end

endmodule

// File: tb/tb_mem_trace_ctrl.sv
// Self-checking bench for mem_trace_ctrl: tracer model with configurable ack delay
// and 2-cycle read latency, scoreboard of expected tracer addresses and drain words.
module tb_mem_trace_ctrl;
  import sigma_tile_pkg::*;

  localparam int unsigned CAPACITY = 256;
  localparam int unsigned AW       = 8;

  logic        clk, rst_n;
  logic        csr_req, csr_we, csr_ack, csr_resp;
  logic [3:0]  csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic [3:0]  trace_ctrl_o;
  logic        trace_flush_end_i;
  logic        trc_req, trc_ack, trc_resp;
  logic [31:0] trc_addr, trc_rdata;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic [1:0]  out_word;

  mem_trace_ctrl #(.CAPACITY(CAPACITY)) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_req(csr_req), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_ack(csr_ack), .csr_resp(csr_resp), .csr_rdata(csr_rdata),
    .trace_ctrl_o(trace_ctrl_o), .trace_flush_end_i(trace_flush_end_i),
    .trc_req(trc_req), .trc_addr(trc_addr), .trc_ack(trc_ack),
    .trc_resp(trc_resp), .trc_rdata(trc_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_word(out_word), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- tracer model ----------------
  logic [31:0]  mem [CAPACITY*4];
  int unsigned  ack_delay, req_wait, outstanding, fcnt;
  logic         lat_pend, resp_q;
  logic [31:0]  lat_addr, resp_data;

  assign trc_ack   = trc_req && (req_wait >= ack_delay);
  assign trc_resp  = resp_q;
  assign trc_rdata = resp_data;
  // flush_end timed so the registered flush bit is high for exactly CAPACITY cycles
  assign trace_flush_end_i = trace_ctrl_o[TRACE_FLUSH_BIT] && (fcnt == CAPACITY - 2);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_wait <= 0; outstanding <= 0; fcnt <= 0;
      lat_pend <= 1'b0; resp_q <= 1'b0; lat_addr <= '0; resp_data <= '0;
    end else begin
      fcnt     <= trace_ctrl_o[TRACE_FLUSH_BIT] ? fcnt + 1 : 0;
      req_wait <= (trc_req && !trc_ack) ? req_wait + 1 : 0;
      lat_pend <= trc_req && trc_ack;
      if (trc_req && trc_ack) lat_addr <= trc_addr;
      resp_q   <= lat_pend;
      if (lat_pend) resp_data <= mem[lat_addr[AW+1:0]];
      outstanding <= outstanding + ((trc_req && trc_ack) ? 1 : 0) - (resp_q ? 1 : 0);
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct packed {
    logic        last;
    logic [1:0]  word;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] exp_addr_q[$];
  int          ready_mode;   // 0 always ready, 1 random, 2 never
  logic        stalled;
  beat_t       held;

  initial begin
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled   = 1'b0;
        out_ready = 1'b0;
      end else begin
        if (stalled)
          check_eq("out_stable", {out_valid, out_last, out_word, out_data}, {1'b1, held});
        case (ready_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = ($urandom_range(0, 1) == 1);
          default: out_ready = 1'b0;
        endcase
        if (trc_req && trc_ack) begin
          check_eq("one_outstanding", outstanding, 0);
          check_eq("trc_expected", exp_addr_q.size() != 0, 1);
          if (exp_addr_q.size() != 0) check_eq("trc_addr", trc_addr, exp_addr_q.pop_front());
        end
        if (out_valid && out_ready) begin
          check_eq("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check_eq("out_beat", {out_last, out_word, out_data}, exp_q.pop_front());
        end
        stalled = out_valid && !out_ready;
        held    = {out_last, out_word, out_data};
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic csr_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_req = 1'b1; csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    @(negedge clk);
    csr_req = 1'b0; csr_we = 1'b0; csr_wdata = '0;
  endtask

  task automatic csr_expect(input string tag, input logic [3:0] a, input logic [31:0] exp);
    @(negedge clk);
    csr_req = 1'b1; csr_we = 1'b0; csr_addr = a;
    @(negedge clk);
    csr_req = 1'b0;
    check_eq({tag, "_resp"}, csr_resp, 1);
    check_eq(tag, csr_rdata, exp);
  endtask

  task automatic load_entry(input int unsigned idx, input logic [31:0] a,
                            input logic [31:0] d, input logic we);
    logic [AW+1:0] base;
    base = (AW+2)'(idx * 4);
    mem[base]         = a;
    mem[base + 10'd1] = d;
    mem[base + 10'd2] = {31'b0, we};
  endtask

  task automatic push_drain(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      for (int unsigned w = 0; w < 3; w++) begin
        logic [AW+1:0] idx;
        beat_t b;
        idx    = (AW+2)'(i * 4 + w);
        b.data = mem[idx];
        b.word = 2'(w);
        b.last = (i == n - 1) && (w == 2);
        exp_addr_q.push_back(32'h400 | {22'b0, idx});
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && exp_addr_q.size() == 0) break;
    end
    check_eq({tag, "_drained"}, exp_q.size() + exp_addr_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic wait_flush(output int hi);
    hi = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (trace_ctrl_o[TRACE_FLUSH_BIT]) hi++;
      else if (hi > 0) break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int hi;
    rst_n = 1'b0; csr_req = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
    out_ready = 1'b0; ready_mode = 0; ack_delay = 0;
    for (int unsigned e = 0; e < CAPACITY; e++) load_entry(e, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("reset_ctrl", {trace_ctrl_o, csr_resp, trc_req, out_valid, out_last, out_word}, '0);
    check_eq("reset_data", {csr_rdata, out_data}, '0);
    check_eq("reset_trc_addr", trc_addr, '0);
    rst_n = 1'b1;

    // 1: enable
    csr_wr(TRC_CSR_CTRL, 32'h1);
    check_eq("en_lag", trace_ctrl_o[TRACE_EN_BIT], 0);
    @(negedge clk);
    check_eq("en_on", trace_ctrl_o, 4'h1);
    csr_expect("status_idle", TRC_CSR_STATUS, 32'h0);

    // 2: flush
    csr_wr(TRC_CSR_CTRL, 32'h3);
    @(negedge clk);
    check_eq("en_during_flush", trace_ctrl_o[TRACE_EN_BIT], 0);
    wait_flush(hi);
    check_eq("flush_len", hi + 1, CAPACITY);
    check_eq("en_after_flush", trace_ctrl_o, 4'h1);
    csr_expect("status_flush_done", TRC_CSR_STATUS, 32'h2);
    csr_wr(TRC_CSR_STATUS, 32'h2);

    // DRAIN_CNT clamping
    csr_wr(TRC_CSR_CNT, 32'd0);
    csr_expect("cnt_zero_clamp", TRC_CSR_CNT, 32'd256);
    csr_wr(TRC_CSR_CNT, 32'd300);
    csr_expect("cnt_big_clamp", TRC_CSR_CNT, 32'd256);
    csr_wr(TRC_CSR_CNT, 32'd2);
    csr_expect("cnt_two", TRC_CSR_CNT, 32'd2);

    // 3: basic drain
    load_entry(0, 32'h100, 32'hAA, 1'b1);
    load_entry(1, 32'h104, 32'hBB, 1'b0);
    push_drain(2);
    csr_wr(TRC_CSR_CTRL, 32'h4);
    wait_drain("drain1");
    csr_expect("status_drain_done", TRC_CSR_STATUS, 32'h4);
    csr_expect("ptr_after_drain", TRC_CSR_PTR, 32'd2);
    csr_wr(TRC_CSR_STATUS, 32'h4);
    csr_expect("status_cleared", TRC_CSR_STATUS, 32'h0);

    // 4: stalls and slow ack
    ack_delay = 3; ready_mode = 1;
    push_drain(2);
    csr_wr(TRC_CSR_CTRL, 32'h4);
    wait_drain("drain2");
    ack_delay = 0; ready_mode = 0;
    csr_expect("status_drain2", TRC_CSR_STATUS, 32'h4);

    // 5: command errors
    csr_wr(TRC_CSR_STATUS, 32'hE);
    csr_wr(TRC_CSR_CTRL, 32'h6);
    csr_wr(TRC_CSR_CTRL, 32'h4);
    csr_expect("status_cmd_err", TRC_CSR_STATUS, 32'h9);
    wait_flush(hi);
    check_eq("flush2_ended", trace_ctrl_o[TRACE_FLUSH_BIT], 0);
    csr_expect("status_after_err", TRC_CSR_STATUS, 32'hA);
    csr_wr(TRC_CSR_STATUS, 32'h8);
    csr_expect("status_err_cleared", TRC_CSR_STATUS, 32'h2);
    csr_wr(4'h2, 32'hFFFF_FFFF);
    csr_expect("unmapped_rd", 4'h2, 32'h0);
    csr_expect("ctrl_untouched", TRC_CSR_CTRL, 32'h0);

    // 6: reset mid-drain
    ready_mode = 2;
    push_drain(2);
    csr_wr(TRC_CSR_CTRL, 32'h4);
    for (int k = 0; k < 100; k++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    check_eq("mid_drain_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_ctrl", {trace_ctrl_o, csr_resp, trc_req, out_valid, out_last, out_word}, '0);
    check_eq("async_rst_data", {csr_rdata, out_data}, '0);
    check_eq("async_rst_trc_addr", trc_addr, '0);
    exp_q.delete();
    exp_addr_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    csr_expect("cnt_after_rst", TRC_CSR_CNT, 32'd256);
    csr_expect("status_after_rst", TRC_CSR_STATUS, 32'h0);
    csr_expect("ptr_after_rst", TRC_CSR_PTR, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
